// File: rtl/memory_bus_interface_if.sv
// rtl/memory_bus_interface_if.sv - core-side request/response and external memory bus signals
interface memory_bus_interface_if;
  logic        req_read;
  logic        req_write;
  logic [7:0]  addr_lowbyte;
  logic [7:0]  addr_highbyte;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_read_en;
  logic        ext_write_en;
  logic        ext_ready;
  logic [7:0]  ext_rdata;

  modport master (
    output req_read, req_write, addr_lowbyte, addr_highbyte, write_data,
    output ext_ready, ext_rdata,
    input  read_data, busy, done, error,
    input  ext_addr, ext_wdata, ext_read_en, ext_write_en
  );

  modport slave (
    input  req_read, req_write, addr_lowbyte, addr_highbyte, write_data,
    input  ext_ready, ext_rdata,
    output read_data, busy, done, error,
    output ext_addr, ext_wdata, ext_read_en, ext_write_en
  );
endinterface

// File: rtl/memory_bus_interface.sv
// rtl/memory_bus_interface.sv - 6502 address-byte to external memory bus bridge with wait-state timeout
module memory_bus_interface #(
  parameter int WAIT_LIMIT = 15
) (
  input logic                    clk,
  input logic                    rst,
  memory_bus_interface_if.slave  bus
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            rd_en, rd_en_n;
  logic            wr_en, wr_en_n;
  logic            done_q, done_n;
  logic            error_q, error_n;
  logic [15:0]     addr, addr_n;
  logic [7:0]      wdata, wdata_n;
  logic [7:0]      rdata, rdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr    <= 16'h0000;
      wdata   <= 8'h00;
      rdata   <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_en   <= rd_en_n;
      wr_en   <= wr_en_n;
      done_q  <= done_n;
      error_q <= error_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      rdata   <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_en_n = rd_en;
    wr_en_n = wr_en;
    done_n  = 1'b0;
    error_n = 1'b0;
    addr_n  = addr;
    wdata_n = wdata;
    rdata_n = rdata;
    unique case (state)
      S_IDLE: begin
        // Read wins a tie; the losing write is dropped, so ext_wdata is left alone.
        if (bus.req_read) begin
          addr_n  = {bus.addr_highbyte, bus.addr_lowbyte};
          rd_en_n = 1'b1;
          cnt_n   = '0;
          state_n = S_ACCESS;
        end else if (bus.req_write) begin
          addr_n  = {bus.addr_highbyte, bus.addr_lowbyte};
          wdata_n = bus.write_data;
          wr_en_n = 1'b1;
          cnt_n   = '0;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ext_ready) begin
          if (rd_en) rdata_n = bus.ext_rdata;
          rd_en_n = 1'b0;
          wr_en_n = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(WAIT_LIMIT)) begin
            rd_en_n = 1'b0;
            wr_en_n = 1'b0;
            error_n = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.read_data    = rdata;
  assign bus.ext_addr     = addr;
  assign bus.ext_wdata    = wdata;
  assign bus.ext_read_en  = rd_en;
  assign bus.ext_write_en = wr_en;
endmodule

// File: tb/tb_memory_bus_interface.sv
// tb/tb_memory_bus_interface.sv - directed self-checking bench for memory_bus_interface
module tb_memory_bus_interface;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_done1 = 0;
  int   t_done2 = 0;

  memory_bus_interface_if bus();

  memory_bus_interface #(.WAIT_LIMIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic request(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] wd);
    bus.req_read      = rd;
    bus.req_write     = wr;
    bus.addr_highbyte = a[15:8];
    bus.addr_lowbyte  = a[7:0];
    bus.write_data    = wd;
  endtask

  initial begin
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    bus.ext_ready = 1'b0;
    bus.ext_rdata = 8'h00;

    // Reset
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_rd_en", bus.ext_read_en, 0);
    check("rst_wr_en", bus.ext_write_en, 0);
    check("rst_addr", bus.ext_addr, 0);
    check("rst_wdata", bus.ext_wdata, 0);
    check("rst_rdata", bus.read_data, 0);
    rst = 1'b0;

    // Read, zero wait states
    request(1'b1, 1'b0, 16'h1234, 8'h00);
    bus.ext_ready = 1'b1;
    bus.ext_rdata = 8'hA5;
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    check("rd_access_busy", bus.busy, 1);
    check("rd_access_addr", bus.ext_addr, 16'h1234);
    check("rd_access_en", bus.ext_read_en, 1);
    check("rd_access_done", bus.done, 0);
    tick();
    check("rd_wait_en", bus.ext_read_en, 1);
    check("rd_wait_busy", bus.busy, 1);
    tick();
    check("rd_done", bus.done, 1);
    check("rd_data", bus.read_data, 8'hA5);
    check("rd_en_drop", bus.ext_read_en, 0);
    check("rd_busy_drop", bus.busy, 0);
    tick();
    check("rd_done_pulse", bus.done, 0);

    // Write at 16'hFFFF with 3 wait states
    bus.ext_ready = 1'b0;
    request(1'b0, 1'b1, 16'hFFFF, 8'h5A);
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    check("wr_access_en", bus.ext_write_en, 1);
    check("wr_access_addr", bus.ext_addr, 16'hFFFF);
    check("wr_access_rd_en", bus.ext_read_en, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wr_wait_en", bus.ext_write_en, 1);
      check("wr_wait_wdata", bus.ext_wdata, 8'h5A);
      check("wr_wait_addr", bus.ext_addr, 16'hFFFF);
      check("wr_wait_done", bus.done, 0);
      if (i == 3) bus.ext_ready = 1'b1;
      tick();
    end
    bus.ext_ready = 1'b0;
    check("wr_done", bus.done, 1);
    check("wr_en_drop", bus.ext_write_en, 0);
    check("wr_rdata_kept", bus.read_data, 8'hA5);

    // Timeout: 15 WAIT cycles with ext_ready low
    request(1'b1, 1'b0, 16'h0042, 8'h00);
    bus.ext_rdata = 8'h77;
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    for (int i = 1; i <= 15; i++) begin
      check("to_wait_busy", bus.busy, 1);
      check("to_wait_error", bus.error, 0);
      tick();
    end
    check("to_error", bus.error, 1);
    check("to_no_done", bus.done, 0);
    check("to_rdata_kept", bus.read_data, 8'hA5);
    check("to_rd_en_drop", bus.ext_read_en, 0);
    check("to_busy_drop", bus.busy, 0);
    tick();
    check("to_error_pulse", bus.error, 0);

    // Simultaneous read+write at 16'h00FF: read only
    request(1'b1, 1'b1, 16'h00FF, 8'h99);
    bus.ext_ready = 1'b1;
    bus.ext_rdata = 8'h3C;
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    check("both_rd_en", bus.ext_read_en, 1);
    check("both_wr_en", bus.ext_write_en, 0);
    check("both_addr", bus.ext_addr, 16'h00FF);
    check("both_wdata", bus.ext_wdata, 8'h5A);
    tick();
    check("both_wait_wr_en", bus.ext_write_en, 0);
    tick();
    check("both_done", bus.done, 1);
    check("both_rdata", bus.read_data, 8'h3C);

    // Reset during WAIT
    bus.ext_ready = 1'b0;
    request(1'b1, 1'b0, 16'h1111, 8'h00);
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    tick();
    check("mid_busy_pre", bus.busy, 1);
    rst = 1'b1;
    tick();
    check("mid_busy", bus.busy, 0);
    check("mid_rd_en", bus.ext_read_en, 0);
    check("mid_done", bus.done, 0);
    check("mid_error", bus.error, 0);
    rst = 1'b0;
    tick();
    check("mid_done_after", bus.done, 0);
    check("mid_error_after", bus.error, 0);

    // Back-to-back reads at 16'h0000 then 16'h0001
    bus.ext_ready = 1'b1;
    request(1'b1, 1'b0, 16'h0000, 8'h00);
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    check("b2b1_addr", bus.ext_addr, 16'h0000);
    bus.ext_rdata = 8'hC1;
    tick();
    tick();
    check("b2b1_done", bus.done, 1);
    check("b2b1_rdata", bus.read_data, 8'hC1);
    t_done1 = cyc;
    request(1'b1, 1'b0, 16'h0001, 8'h00);
    tick();
    request(1'b0, 1'b0, 16'h0000, 8'h00);
    check("b2b2_done_pulse", bus.done, 0);
    check("b2b2_addr", bus.ext_addr, 16'h0001);
    check("b2b2_rd_en", bus.ext_read_en, 1);
    bus.ext_rdata = 8'hC2;
    tick();
    tick();
    check("b2b2_done", bus.done, 1);
    check("b2b2_rdata", bus.read_data, 8'hC2);
    t_done2 = cyc;
    check("b2b_spacing", t_done2 - t_done1, 3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
